// File: rtl/pad_in_cond.sv
// pad_in_cond: receive-side conditioner for bidirectional IO pads.
// Per pin: synchronises the asynchronous pad input-sense bit into clk,
// optionally debounces it, detects rising/falling edges of the filtered
// value and keeps sticky, write-1-to-clear interrupt-pending bits.
//
// Ports
//   clk        core clock
//   rst_n      asynchronous active-low reset (synchronous release upstream)
//   pad_i      [DW]        raw pad input-sense, asynchronous to clk
//   db_en      1 = debounce enabled for all pins
//   db_thresh  [DB_CNT_W]  required consecutive stable cycles (0 acts as 1)
//   rise_ie    [DW]        per-pin rising-edge interrupt enable
//   fall_ie    [DW]        per-pin falling-edge interrupt enable
//   ip_clr     [DW]        per-pin single-cycle clear of both pending bits
//   in_val     [DW]        conditioned pin value (registered)
//   rise_ip    [DW]        sticky rising-edge pending (registered)
//   fall_ip    [DW]        sticky falling-edge pending (registered)
//   irq        OR of all pending bits, combinational from the pending flops
module pad_in_cond #(
   parameter int unsigned DW          = 8,
   parameter int unsigned SYNC_STAGES = 2,   // legal range 2..4
   parameter int unsigned DB_CNT_W    = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [DW-1:0]       pad_i,
   input  logic                db_en,
   input  logic [DB_CNT_W-1:0] db_thresh,
   input  logic [DW-1:0]       rise_ie,
   input  logic [DW-1:0]       fall_ie,
   input  logic [DW-1:0]       ip_clr,
   output logic [DW-1:0]       in_val,
   output logic [DW-1:0]       rise_ip,
   output logic [DW-1:0]       fall_ip,
   output logic                irq
);

   // The filter flop is the final resolving stage of the synchroniser, so the
   // raw chain ahead of it is one flop shorter than SYNC_STAGES. This gives a
   // pad-to-in_val latency of SYNC_STAGES edges in bypass mode.
   localparam int unsigned SYNC_W = SYNC_STAGES - 1;

   logic [SYNC_W-1:0][DW-1:0]   sync_q;
   logic [DW-1:0]               sync_last;

   logic [DW-1:0]               filt_q;
   logic [DW-1:0]               filt_d;
   logic [DW-1:0][DB_CNT_W-1:0] cnt_q;
   logic [DW-1:0][DB_CNT_W-1:0] cnt_d;

   logic [DW-1:0]               rise_q;
   logic [DW-1:0]               rise_d;
   logic [DW-1:0]               fall_q;
   logic [DW-1:0]               fall_d;

   logic [DB_CNT_W-1:0]         thresh_m1;
   logic [DW-1:0]               rise_set;
   logic [DW-1:0]               fall_set;

   // Plain flop chain, nothing between stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= pad_i;
         for (int s = 1; s < SYNC_W; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
      end
   end

   assign sync_last = sync_q[SYNC_W-1];

   // T-1, with a zero threshold behaving as a threshold of one.
   assign thresh_m1 = (db_thresh == '0) ? '0 : DB_CNT_W'(db_thresh - 1'b1);

   // Debounce / bypass next-state per pin.
   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      for (int i = 0; i < DW; i++) begin
         if (!db_en) begin
            filt_d[i] = sync_last[i];
         end else if (sync_last[i] != filt_q[i]) begin
            // >= rather than == so a threshold lowered mid-count commits
            // promptly instead of wrapping the counter.
            if (cnt_q[i] >= thresh_m1) begin
               filt_d[i] = sync_last[i];
            end else begin
               cnt_d[i] = DB_CNT_W'(cnt_q[i] + 1'b1);
            end
         end
      end
   end

   // Edges are taken from filt_d so pending bits set with in_val.
   assign rise_set = filt_d & ~filt_q & rise_ie;
   assign fall_set = ~filt_d & filt_q & fall_ie;

   // Set wins over a same-cycle clear.
   assign rise_d = rise_set | (rise_q & ~ip_clr);
   assign fall_d = fall_set | (fall_q & ~ip_clr);

   // Filter, counter and pending state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_q <= '0;
         cnt_q  <= '0;
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         filt_q <= filt_d;
         cnt_q  <= cnt_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign in_val  = filt_q;
   assign rise_ip = rise_q;
   assign fall_ip = fall_q;
   assign irq     = |(rise_q | fall_q);

endmodule
